// File: rtl/pushbutton_pkg.sv
// Shared types and constants for the debounced pushbutton toggle bank.
// Long-press support is controlled by the macro PUSHBUTTON_LONG_PRESS_EN.
package pushbutton_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCKOUT = 2'd1,
        HELD    = 2'd2
    } pb_state_e;

    // 20 ms tick from a 50 MHz clk_ms
    localparam int unsigned DEFAULT_CLK_DIV = 1000000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pushbutton_toggle_bank_if.sv
// Button bank signal bundle: raw button levels in, toggle state and pulses out.
interface pushbutton_toggle_bank_if #(
    parameter int unsigned CHANNELS = 4
);
    logic [CHANNELS-1:0] pressed;
    logic [CHANNELS-1:0] state;
    logic [CHANNELS-1:0] press_pulse;
    logic [CHANNELS-1:0] long_pulse;

    modport master (output pressed, input state, input press_pulse, input long_pulse);
    modport slave  (input pressed, output state, output press_pulse, output long_pulse);
endinterface

// File: rtl/pushbutton_channel.sv
// One debounced toggle button: synchroniser, lockout FSM, tick counter, outputs.
// PUSHBUTTON_LONG_PRESS_EN compiles in the long-press pulse.
module pushbutton_channel
    import pushbutton_pkg::*;
#(
    parameter int unsigned LOCKOUT_TICKS = 10
`ifdef PUSHBUTTON_LONG_PRESS_EN
    , parameter int unsigned LONG_TICKS = 50
`endif
) (
    input  logic clk_ms,
    input  logic reset,
    input  logic tick,
    input  logic pressed,
    output logic state,
    output logic press_pulse,
    output logic long_pulse
);
`ifdef PUSHBUTTON_LONG_PRESS_EN
    localparam int unsigned CNT_TOP = max_u(LOCKOUT_TICKS, LONG_TICKS);
`else
    localparam int unsigned CNT_TOP = LOCKOUT_TICKS;
`endif
    localparam int unsigned CNT_W = $clog2(CNT_TOP + 1);

    logic             sync1, pressed_s;
    pb_state_e        cur, nxt;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic             state_n, press_pulse_n;

    // Synchroniser resets high so a button held through reset reads as held
    always_ff @(posedge clk_ms) begin
        if (reset) begin
            sync1     <= 1'b1;
            pressed_s <= 1'b1;
        end else begin
            sync1     <= pressed;
            pressed_s <= sync1;
        end
    end

    assign cnt_inc = (tick && cnt != '1) ? cnt + 1'b1 : cnt;

`ifdef PUSHBUTTON_LONG_PRESS_EN
    logic long_done, long_done_n, long_pulse_n;
`endif

    always_comb begin
        nxt           = cur;
        cnt_n         = cnt;
        state_n       = state;
        press_pulse_n = 1'b0;
`ifdef PUSHBUTTON_LONG_PRESS_EN
        long_done_n   = long_done;
        long_pulse_n  = 1'b0;
`endif
        case (cur)
            IDLE: begin
                if (pressed_s) begin
                    press_pulse_n = 1'b1;
                    state_n       = ~state;
                    cnt_n         = '0;
`ifdef PUSHBUTTON_LONG_PRESS_EN
                    long_done_n   = 1'b0;
`endif
                    nxt           = LOCKOUT;
                end
            end
            LOCKOUT: begin
                cnt_n = cnt_inc;
                if (cnt == CNT_W'(LOCKOUT_TICKS))
                    nxt = pressed_s ? HELD : IDLE;
            end
            HELD: begin
`ifdef PUSHBUTTON_LONG_PRESS_EN
                cnt_n = cnt_inc;
`endif
                if (!pressed_s)
                    nxt = IDLE;
            end
            default: nxt = HELD;
        endcase
`ifdef PUSHBUTTON_LONG_PRESS_EN
        if ((cur == LOCKOUT || cur == HELD) && cnt == CNT_W'(LONG_TICKS) && !long_done) begin
            long_pulse_n = 1'b1;
            long_done_n  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_ms) begin
        if (reset) begin
            cur         <= HELD;
            cnt         <= '0;
            state       <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            cur         <= nxt;
            cnt         <= cnt_n;
            state       <= state_n;
            press_pulse <= press_pulse_n;
        end
    end

`ifdef PUSHBUTTON_LONG_PRESS_EN
    always_ff @(posedge clk_ms) begin
        if (reset) begin
            long_done  <= 1'b1;
            long_pulse <= 1'b0;
        end else begin
            long_done  <= long_done_n;
            long_pulse <= long_pulse_n;
        end
    end
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/pushbutton_toggle_bank.sv
// Bank of CHANNELS debounced toggle buttons sharing one tick prescaler.
// PUSHBUTTON_LONG_PRESS_EN enables the per-channel long-press pulse.
module pushbutton_toggle_bank
    import pushbutton_pkg::*;
#(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned CLK_DIV       = DEFAULT_CLK_DIV,
    parameter int unsigned LOCKOUT_TICKS = 10,
    parameter int unsigned LONG_TICKS    = 50
) (
    input logic                     clk_ms,
    input logic                     reset,
    pushbutton_toggle_bank_if.slave bus
);
    localparam int unsigned DIV_W = $clog2(CLK_DIV);

    if (CHANNELS < 1 || CLK_DIV < 2 || LOCKOUT_TICKS < 1 || LONG_TICKS <= LOCKOUT_TICKS) begin : g_param_err
        $error("pushbutton_toggle_bank: illegal parameter combination");
    end

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk_ms) begin
        if (reset || tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pushbutton_channel #(
            .LOCKOUT_TICKS(LOCKOUT_TICKS)
`ifdef PUSHBUTTON_LONG_PRESS_EN
            , .LONG_TICKS(LONG_TICKS)
`endif
        ) u_ch (
            .clk_ms     (clk_ms),
            .reset      (reset),
            .tick       (tick),
            .pressed    (bus.pressed[i]),
            .state      (bus.state[i]),
            .press_pulse(bus.press_pulse[i]),
            .long_pulse (bus.long_pulse[i])
        );
    end

endmodule

// File: tb/tb_pushbutton_toggle_bank.sv
// Directed self-checking bench for pushbutton_toggle_bank (2 channels, CLK_DIV=4).
// Expectations adapt to whether PUSHBUTTON_LONG_PRESS_EN is defined.
module tb_pushbutton_toggle_bank;
    localparam int unsigned CH = 2;
`ifdef PUSHBUTTON_LONG_PRESS_EN
    localparam int LP_EXP = 1;
`else
    localparam int LP_EXP = 0;
`endif

    logic clk_ms = 1'b0;
    logic reset  = 1'b1;

    pushbutton_toggle_bank_if #(.CHANNELS(CH)) bus ();

    pushbutton_toggle_bank #(
        .CHANNELS     (CH),
        .CLK_DIV      (4),
        .LOCKOUT_TICKS(3),
        .LONG_TICKS   (8)
    ) dut (
        .clk_ms(clk_ms),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk_ms = ~clk_ms;

    int n_checks = 0;
    int n_pass   = 0;

    // Pulse monitor: running totals and last pulse cycle, sampled on the falling edge
    int cyc = 0;
    int pp_cnt[CH] = '{default: 0};
    int lp_cnt[CH] = '{default: 0};
    int pp1_cyc = 0;
    int lp1_cyc = 0;

    always @(negedge clk_ms) begin
        cyc <= cyc + 1;
        if (!reset) begin
            for (int i = 0; i < CH; i++) begin
                if (bus.press_pulse[i]) pp_cnt[i] <= pp_cnt[i] + 1;
                if (bus.long_pulse[i])  lp_cnt[i] <= lp_cnt[i] + 1;
            end
            if (bus.press_pulse[1]) pp1_cyc <= cyc;
            if (bus.long_pulse[1])  lp1_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_ms);
    endtask

    int pp_a[CH];
    int lp_a[CH];

    task automatic snap();
        for (int i = 0; i < CH; i++) begin
            pp_a[i] = pp_cnt[i];
            lp_a[i] = lp_cnt[i];
        end
    endtask

    initial begin
        bus.pressed = '0;
        cycles(3);
        check("reset_state", 32'(bus.state), 32'd0);
        check("reset_press", 32'(bus.press_pulse), 32'd0);
        check("reset_long",  32'(bus.long_pulse), 32'd0);
        reset = 1'b0;
        cycles(10);

        // Single press on channel 0, 2 cycles long
        bus.pressed = 2'b01;
        cycles(1);
        check("t1_pp_e0", 32'(bus.press_pulse), 32'd0);
        cycles(1);
        check("t1_pp_e1", 32'(bus.press_pulse), 32'd0);
        bus.pressed = 2'b00;
        cycles(1);
        check("t1_pp_e2", 32'(bus.press_pulse), 32'b01);
        check("t1_state", 32'(bus.state), 32'b01);
        cycles(1);
        check("t1_pp_width", 32'(bus.press_pulse), 32'd0);
        check("t1_state_hold", 32'(bus.state), 32'b01);
        cycles(25);

        // Bounce then hold on channel 0
        snap();
        for (int i = 0; i < 8; i++) begin
            bus.pressed[0] = (i % 2 == 0);
            cycles(1);
        end
        bus.pressed[0] = 1'b1;
        cycles(40);
        check("t2_state_held", 32'(bus.state), 32'b00);
        bus.pressed[0] = 1'b0;
        cycles(25);
        check("t2_pp_once", 32'(pp_cnt[0] - pp_a[0]), 32'd1);
        check("t2_long",    32'(lp_cnt[0] - lp_a[0]), 32'(LP_EXP));
        check("t2_state",   32'(bus.state), 32'b00);

        // Long press on channel 1
        snap();
        bus.pressed[1] = 1'b1;
        cycles(40);
        check("t3_state", 32'(bus.state), 32'b10);
        check("t3_pp_once", 32'(pp_cnt[1] - pp_a[1]), 32'd1);
        check("t3_long",    32'(lp_cnt[1] - lp_a[1]), 32'(LP_EXP));
        if (LP_EXP == 1)
            check("t3_long_latency", 32'((lp1_cyc - pp1_cyc) >= 30 && (lp1_cyc - pp1_cyc) <= 33), 32'd1);
        check("t3_ch0_quiet", 32'(pp_cnt[0] - pp_a[0]), 32'd0);
        bus.pressed[1] = 1'b0;
        cycles(30);
        check("t3_long_norepeat", 32'(lp_cnt[1] - lp_a[1]), 32'(LP_EXP));
        bus.pressed[1] = 1'b1;
        cycles(2);
        bus.pressed[1] = 1'b0;
        cycles(25);
        check("t3_state_back", 32'(bus.state), 32'b00);

        // Simultaneous press on both channels
        bus.pressed = 2'b11;
        cycles(2);
        bus.pressed = 2'b00;
        cycles(1);
        check("t4_pp_both", 32'(bus.press_pulse), 32'b11);
        check("t4_state",   32'(bus.state), 32'b11);
        cycles(25);

        // Reset during lockout with channel 0 held
        bus.pressed = 2'b01;
        cycles(3);
        check("t5_pp", 32'(bus.press_pulse), 32'b01);
        check("t5_state_pre", 32'(bus.state), 32'b10);
        cycles(2);
        reset = 1'b1;
        cycles(1);
        check("t5_rst_state", 32'(bus.state), 32'd0);
        check("t5_rst_pp",    32'(bus.press_pulse), 32'd0);
        check("t5_rst_lp",    32'(bus.long_pulse), 32'd0);
        reset = 1'b0;
        snap();
        cycles(60);
        check("t5_no_pp",   32'(pp_cnt[0] - pp_a[0]), 32'd0);
        check("t5_no_lp",   32'(lp_cnt[0] - lp_a[0]), 32'd0);
        check("t5_state_held", 32'(bus.state), 32'b00);
        bus.pressed = 2'b00;
        cycles(10);
        bus.pressed = 2'b01;
        cycles(2);
        bus.pressed = 2'b00;
        cycles(1);
        check("t5_repress_pp",    32'(bus.press_pulse), 32'b01);
        check("t5_repress_state", 32'(bus.state), 32'b01);
        cycles(25);

        // 100-cycle hold on channel 1
        snap();
        bus.pressed[1] = 1'b1;
        cycles(100);
        check("t6_long_100", 32'(lp_cnt[1] - lp_a[1]), 32'(LP_EXP));
        bus.pressed[1] = 1'b0;
        cycles(20);
        check("t6_long_total", 32'(lp_cnt[0] + lp_cnt[1]), 32'(3 * LP_EXP));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pushbutton_toggle_bank.md
# pushbutton_toggle_bank

Parametrised bank of `CHANNELS` independent debounced toggle pushbuttons. All channels share one `clk_ms` domain and one tick prescaler. Each channel:
- synchronises its raw button input;
- emits a single-cycle press pulse and flips a toggle state on each accepted press;
- ignores its input for a lockout window;
- requires release before re-arming, so a held button never re-toggles.

An optional long-press pulse is available. The bank replaces per-button toggle wrappers in the start/stop, lap and reset control path of the stopwatch.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent buttons (≥1).
- `CLK_DIV`, 1000000: `clk_ms` cycles per tick (≥2); 10^6 gives 20 ms at 50 MHz.
- `LOCKOUT_TICKS`, 10: ticks of input lockout after an accepted press (≥1).
- `LONG_TICKS`, 50: ticks from press to long-press pulse (> `LOCKOUT_TICKS`); used only with `LONG_PRESS_EN`.

Ports:
- `clk_ms` in 1: master clock. One clock only; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `pressed` in `CHANNELS`: raw, asynchronous button levels, 1 = pressed.
- `state` out `CHANNELS`: toggle state per channel; reset 0.
- `press_pulse` out `CHANNELS`: one-cycle pulse per accepted press; reset 0.
- `long_pulse` out `CHANNELS`: one-cycle pulse per long press; reset 0. Tied 0 without `LONG_PRESS_EN`.

## Operation
- **Prescaler.** The counter runs 0..`CLK_DIV`-1 and wraps. `tick` is high for one cycle when the count equals `CLK_DIV`-1. Reset value 0.
- **Synchroniser.** Two flops per channel produce `pressed_s`. Both flops reset to 1, so a button held through reset is treated as already held.
- **Per-channel FSM** (reset state HELD):
  - IDLE: if `pressed_s`=1, register `press_pulse`=1, flip `state`, clear the tick counter, clear `long_done`, go to LOCKOUT.
  - LOCKOUT: input ignored; the counter increments on `tick`. When the counter equals `LOCKOUT_TICKS`: go to HELD if `pressed_s`=1, else go to IDLE.
  - HELD: when `pressed_s`=0, go to IDLE. The counter keeps incrementing on `tick`.
- **Long press** (with `LONG_PRESS_EN`): in LOCKOUT or HELD, when the counter reaches `LONG_TICKS` and `long_done`=0, register `long_pulse`=1 and set `long_done`. `long_pulse` fires at most once per press. `state` is not altered by a long press.
- **Counter width.** `$clog2(max(LOCKOUT_TICKS,LONG_TICKS)+1)` bits, saturating at its maximum. No wrap, so no spurious second long pulse.
- **Reset values.** `long_done` resets to 1, so no long pulse occurs for a button held through reset.
- **Channel independence.** Channels never interact. Simultaneous presses on several channels are each accepted in the same cycle.
- **Tick and press in the same cycle.** A tick coinciding with the IDLE→LOCKOUT cycle is not counted; the counter is cleared.
- **Reset mid-operation.** Reset in any state returns all outputs to 0 and the FSM to HELD. The channel re-arms only after its synchronised input reads 0.

## Timing
- **Press latency.** `pressed` is first sampled high at edge E0. `press_pulse` and the new `state` are visible after E2 (3 edges). `press_pulse` lasts exactly one cycle.
- **Lockout duration.** Between `LOCKOUT_TICKS`-1 and `LOCKOUT_TICKS` tick periods plus 1 cycle (tick phase jitter).
- **Re-arm.** The earliest next accepted press comes 1 cycle after IDLE is re-entered.
- **Long press.** `long_pulse` is asserted in the cycle after the counter reaches `LONG_TICKS`.
- **Registered outputs.** All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro `PUSHBUTTON_LONG_PRESS_EN`.
- **Defined:** `long_done`, the `LONG_TICKS` comparison and the `long_pulse` driver are compiled in.
- **Undefined:** `long_pulse` is constant 0. The counter width uses `LOCKOUT_TICKS` only and the counter stops incrementing in HELD. `LONG_TICKS` is ignored.

## Structure
- **Shared package** `pushbutton_pkg`: FSM state encoding (IDLE, LOCKOUT, HELD as 2-bit constants) and the default tick constant for 50 Hz at 50 MHz.
- **Sub-module** `pushbutton_channel`: synchroniser, FSM, tick counter and outputs for one channel. It receives `clk_ms`, `reset` and `tick`, and is instantiated `CHANNELS` times via generate.
- **Top level:** the shared prescaler lives in the top level.

## Test plan
Unless stated otherwise: `CHANNELS`=2, `CLK_DIV`=4, `LOCKOUT_TICKS`=3, `LONG_TICKS`=8, `LONG_PRESS_EN` defined.
- **Single press.** Assert `pressed[0]` for 2 cycles, then release → `press_pulse[0]` is high for 1 cycle, 3 edges after the first sampled high; `state[0]` goes 0→1; channel 1 is unchanged.
- **Bounce and hold.** Toggle `pressed[0]` every cycle for 8 cycles, then hold for 40 cycles → exactly one `press_pulse`, `state` flips once, and there is no second toggle while held.
- **Long press.** Hold `pressed[1]` for 40 cycles → one `press_pulse[1]`; one `long_pulse[1]` about 8 ticks (≈32 cycles) after the press, never repeated. Release and press again → `state[1]` returns to 0.
- **Simultaneous presses.** Press both channels in the same cycle → both `press_pulse` bits assert in the same cycle and `state`=2'b11.
- **Reset mid-operation.** Assert `reset` for 1 cycle during LOCKOUT with `pressed[0]` held → all outputs 0. No toggle until release then re-press, and no `long_pulse` for the held press.
- **Macro undefined.** Hold a button for 100 cycles → `long_pulse` stays 0 throughout.
